// File: rtl/modulus_slice_scheduler.sv
// Round-robin time-slice scheduler: one requester at a time owns a shared
// enable-gated modulus counter for cur_len ticks, then the grant rotates.
module modulus_slice_scheduler #(
  parameter int NREQ    = 4,
  parameter int CW      = 3,
  parameter int DEF_LEN = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            len_wr_i,
  input  logic [CW-1:0]   len_wr_data_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            busy_o,
  output logic [CW-1:0]   count_o,
  output logic [CW-1:0]   cur_len_o,
  output logic            slice_done_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   cur_len_q, cur_len_d;
  logic [CW-1:0]   len_q, len_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic            terminal, release_hit;
  logic [IW-1:0]   win_idle, win_run;

  // First set request bit strictly after base, wrapping; base itself is tried last.
  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r, input logic [IW-1:0] base);
    logic [IW-1:0] res;
    logic          found;
    int            idx;
    res   = base;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(base) + k) % NREQ;
      if (!found && r[idx]) begin
        res   = IW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign terminal    = enable_i && (count_q == CW'(cur_len_q - CW'(1)));
  assign release_hit = ~|(req_i & gnt_q);
  assign win_idle    = pick(req_i, last_q);
  assign win_run     = pick(req_i, gidx_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    count_d   = count_q;
    cur_len_d = cur_len_q;
    len_d     = len_q;
    done_d    = 1'b0;

    if (len_wr_i && (len_wr_data_i != '0)) len_d = len_wr_data_i;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d   = RUN;
          gidx_d    = win_idle;
          gnt_d     = NREQ'(1) << win_idle;
          cur_len_d = len_q;
          count_d   = '0;
        end
      end
      RUN: begin
        // Terminal takes precedence over release so a coinciding drop still reports completion.
        if (terminal || release_hit) begin
          count_d = '0;
          done_d  = terminal;
          last_d  = gidx_q;
          if (|req_i) begin
            gidx_d    = win_run;
            gnt_d     = NREQ'(1) << win_run;
            cur_len_d = len_q;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (enable_i) begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = |gnt_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gidx_q    <= IW'(NREQ - 1);
      last_q    <= IW'(NREQ - 1);
      count_q   <= '0;
      cur_len_q <= CW'(DEF_LEN);
      len_q     <= CW'(DEF_LEN);
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      count_q   <= count_d;
      cur_len_q <= cur_len_d;
      len_q     <= len_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign busy_o       = busy_q;
  assign count_o      = count_q;
  assign cur_len_o    = cur_len_q;
  assign slice_done_o = done_q;

endmodule

// File: doc/modulus_slice_scheduler.md
Name: modulus_slice_scheduler

Overview:
Round-robin time-slice scheduler built around an internal enable-gated modulus counter. It shares the counter between NREQ requesters. Each grant lasts one slice of cur_len enabled ticks, and slice length is configured through a write port. Downstream logic uses gnt, count and slice_done to sequence per-requester work on the shared resource.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 3, counter width in bits
DEF_LEN, 5, slice length (modulus) after reset; legal range 1..2^CW-1

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset
enable  in  1  tick enable; count advances only when high
req  in  NREQ  per-requester request, level-sensitive
len_wr  in  1  write strobe for slice length
len_wr_data  in  CW  new slice length
gnt  out  NREQ  one-hot grant, registered; all zero when idle
busy  out  1  high while any gnt bit is set
count  out  CW  current tick within the slice, registered
cur_len  out  CW  length latched for the active slice
slice_done  out  1  one-cycle pulse on slice completion

Behaviour:
- Reset (rst=0 at an edge):
  - gnt=0, busy=0, count=0, slice_done=0.
  - len_reg=DEF_LEN, cur_len=DEF_LEN.
  - RR pointer last=NREQ-1, so req[0] wins first.
  - Reset overrides every other input, including a mid-slice reset.
- Length register:
  - When len_wr=1 and len_wr_data!=0, len_reg<=len_wr_data.
  - Writes of 0 are ignored.
  - len_reg is copied to cur_len only at a grant edge. A write during a slice never alters the active slice.
  - If a write and a grant occur at the same edge, the grant uses the old len_reg.
- States: IDLE (gnt=0) and RUN (gnt one-hot).
- Arbitration: the winner is the first set req bit searching from index (last+1) mod NREQ upward with wrap.
- IDLE:
  - If req!=0 at an edge, then at that edge: gnt<=onehot(winner), cur_len<=len_reg, count<=0, state<=RUN.
  - Grant is visible the cycle after req is sampled.
  - Otherwise IDLE holds.
- RUN, count:
  - When enable=1 and count!=cur_len-1: count<=count+1.
  - When enable=0: count holds.
- RUN, terminal (enable=1 and count==cur_len-1):
  - count<=0, slice_done<=1 for exactly one cycle, last<=granted index.
  - The next winner is selected at the same edge from the current req using the updated pointer. If req=0, go to IDLE with gnt<=0.
  - No idle gap between back-to-back slices; a sole requester is re-granted.
- RUN, release (granted req bit low at an edge, not terminal):
  - Slice aborts: count<=0, no slice_done, last<=granted index.
  - Re-arbitrate as at terminal, or go IDLE.
  - If release and terminal coincide, treat as terminal: slice_done=1.
- enable=0 does not block grant, release or re-arbitration; it only freezes count.
- cur_len=1: every enabled cycle is terminal; count stays 0 and slice_done pulses each enabled cycle.
- busy equals |gnt, registered.
- count never exceeds cur_len-1. Wrap is to 0, with no intermediate values.
- slice_done is registered and coincides with the cycle where count shows 0 after a wrap.

Test Plan:
- Reset: hold rst=0 for 2 edges with req=4'b1111, enable=1. Expect gnt=0, count=0, cur_len=5, slice_done=0. Release rst; expect gnt=4'b0001 one cycle later.
- Single requester, req=4'b0100, enable=1:
  - gnt=4'b0100 and count runs 0,1,2,3,4,0.
  - slice_done pulses 1 cycle at the wrap; gnt stays 4'b0100.
  - Drop req; expect IDLE and gnt=0.
- Round robin, req=4'b1111, enable=1:
  - gnt sequence 0001,0010,0100,1000,0001, each held 5 cycles.
  - One slice_done per handover and no idle cycles.
- Length config:
  - During a slice, pulse len_wr with 3. The current slice completes at 5 ticks; the next has cur_len=3 (count 0,1,2).
  - Then write 0; cur_len stays 3 on the following grant.
- Release:
  - With req=4'b0011, drop req[0] at count=2. Next edge: gnt=4'b0010, count=0, slice_done=0.
  - Also drop req at count==cur_len-1 with enable=1; expect slice_done=1.
- Enable and reset:
  - Toggle enable 1,0,1,0; count advances only on enable=1 edges.
  - Assert rst=0 at count=3 mid-slice; next edge shows gnt=0, count=0, cur_len=DEF_LEN.
